// File: rtl/sort_engine.sv
// Odd-even transposition sorter: one compare/swap pass per cycle, carries original indices.
// Optional macro SORT_EARLY_EXIT_EN stops after two consecutive swap-free passes.
module sort_engine #(
  parameter int DATA_W = 18,
  parameter int NUM    = 16,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    descend,
  input  logic [DATA_W*NUM-1:0]   in_data,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W*NUM-1:0]   sorted_data,
  output logic [IDX_W*NUM-1:0]    sorted_index
);

  typedef enum logic [1:0] {IDLE, SORT, FIN} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] val     [NUM];
  logic [IDX_W-1:0]         idx     [NUM];
  logic signed [DATA_W-1:0] nxt_val [NUM];
  logic [IDX_W-1:0]         nxt_idx [NUM];
  logic [IDX_W-1:0]         pass_cnt;
  logic                     desc_q;
  logic                     last_pass;
`ifdef SORT_EARLY_EXIT_EN
  logic                     any_swap;
  logic                     prev_quiet;
`endif

  // Pass parity selects which disjoint pairs are compared; equal values never swap.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      nxt_val[i] = val[i];
      nxt_idx[i] = idx[i];
    end
`ifdef SORT_EARLY_EXIT_EN
    any_swap = 1'b0;
`endif
    for (int j = 0; j < NUM - 1; j++) begin
      if (j[0] == pass_cnt[0]) begin
        if (desc_q ? (val[j] < val[j+1]) : (val[j] > val[j+1])) begin
          nxt_val[j]   = val[j+1];
          nxt_val[j+1] = val[j];
          nxt_idx[j]   = idx[j+1];
          nxt_idx[j+1] = idx[j];
`ifdef SORT_EARLY_EXIT_EN
          any_swap     = 1'b1;
`endif
        end
      end
    end
`ifdef SORT_EARLY_EXIT_EN
    last_pass = (pass_cnt == IDX_W'(NUM - 1)) || (!any_swap && prev_quiet);
`else
    last_pass = (pass_cnt == IDX_W'(NUM - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= '0;
      desc_q   <= 1'b0;
      sorted_data <= '0;
      for (int k = 0; k < NUM; k++) begin
        val[k] <= '0;
        idx[k] <= '0;
        sorted_index[k*IDX_W +: IDX_W] <= IDX_W'(k);
      end
`ifdef SORT_EARLY_EXIT_EN
      prev_quiet <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM; k++) begin
              val[k] <= in_data[k*DATA_W +: DATA_W];
              idx[k] <= IDX_W'(k);
            end
            desc_q   <= descend;
            pass_cnt <= '0;
            busy     <= 1'b1;
            state    <= SORT;
`ifdef SORT_EARLY_EXIT_EN
            prev_quiet <= 1'b0;
`endif
          end
        end
        SORT: begin
          for (int k = 0; k < NUM; k++) begin
            val[k] <= nxt_val[k];
            idx[k] <= nxt_idx[k];
          end
          pass_cnt <= pass_cnt + 1'b1;
`ifdef SORT_EARLY_EXIT_EN
          prev_quiet <= !any_swap;
`endif
          if (last_pass) state <= FIN;
        end
        FIN: begin
          for (int k = 0; k < NUM; k++) begin
            sorted_data[k*DATA_W +: DATA_W] <= val[k];
            sorted_index[k*IDX_W +: IDX_W]  <= idx[k];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine against a stable insertion-sort reference model.
module tb_sort_engine;
  localparam int DATA_W = 18;
  localparam int NUM    = 16;
  localparam int IDX_W  = 4;
  localparam int LAT    = NUM + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  descend;
  logic [DATA_W*NUM-1:0] in_data;
  logic                  busy;
  logic                  done;
  logic [DATA_W*NUM-1:0] sorted_data;
  logic [IDX_W*NUM-1:0]  sorted_index;

  sort_engine #(.DATA_W(DATA_W), .NUM(NUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .descend(descend), .in_data(in_data),
    .busy(busy), .done(done), .sorted_data(sorted_data), .sorted_index(sorted_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic signed [DATA_W-1:0] in_vals [NUM];
  logic [DATA_W*NUM-1:0]    exp_data;
  logic [IDX_W*NUM-1:0]     exp_index;
  logic [IDX_W*NUM-1:0]     ident_index;

  // Reference: stable insertion sort; a later element only moves ahead of a strictly "worse" one.
  task automatic build_expected(input bit desc);
    logic signed [DATA_W-1:0] v [NUM];
    int p [NUM];
    logic signed [DATA_W-1:0] kv;
    int kp, j;
    for (int i = 0; i < NUM; i++) begin
      v[i] = in_vals[i];
      p[i] = i;
    end
    for (int i = 1; i < NUM; i++) begin
      kv = v[i];
      kp = p[i];
      j  = i - 1;
      while (j >= 0) begin
        if (desc ? (kv > v[j]) : (kv < v[j])) begin
          v[j+1] = v[j];
          p[j+1] = p[j];
          j--;
        end else break;
      end
      v[j+1] = kv;
      p[j+1] = kp;
    end
    for (int k = 0; k < NUM; k++) begin
      exp_data[k*DATA_W +: DATA_W] = v[k];
      exp_index[k*IDX_W +: IDX_W]  = IDX_W'(p[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_inputs();
    for (int k = 0; k < NUM; k++) in_data[k*DATA_W +: DATA_W] = in_vals[k];
  endtask

  task automatic launch(input bit desc);
    pack_inputs();
    descend = desc;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Returns the number of edges until done is seen, or -1 if the budget expires.
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; descend = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
    else passed++;
    checks++;
    if (sorted_data !== '0) $display("[TB] FAIL reset_data: got %h, expected 0", sorted_data);
    else passed++;
    checks++;
    if (sorted_index !== ident_index) $display("[TB] FAIL reset_index: got %h, expected %h", sorted_index, ident_index);
    else passed++;
  endtask

  task automatic test_reverse();
    int lat;
    for (int i = 0; i < NUM; i++) in_vals[i] = DATA_W'(NUM - 1 - i);
    build_expected(1'b0);
    launch(1'b0);
    wait_done(40, lat);
    checks++;
    if (lat !== LAT) $display("[TB] FAIL reverse_latency: got %0d, expected %0d", lat, LAT);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reverse_busy_with_done: got %b, expected 0", busy);
    else passed++;
    checks++;
    if (sorted_data !== exp_data) $display("[TB] FAIL reverse_data: got %h, expected %h", sorted_data, exp_data);
    else passed++;
    checks++;
    if (sorted_index !== exp_index) $display("[TB] FAIL reverse_index: got %h, expected %h", sorted_index, exp_index);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b0) $display("[TB] FAIL reverse_done_pulse: got %b, expected 0", done);
    else passed++;
  endtask

  task automatic test_stability();
    int lat;
    for (int i = 0; i < NUM; i++) in_vals[i] = '0;
    in_vals[0] = -1;
    build_expected(1'b0);
    launch(1'b0);
    wait_done(40, lat);
    checks++;
    if (lat !== LAT) $display("[TB] FAIL stable_latency: got %0d, expected %0d", lat, LAT);
    else passed++;
    checks++;
    if (sorted_data !== exp_data) $display("[TB] FAIL stable_data: got %h, expected %h", sorted_data, exp_data);
    else passed++;
    checks++;
    if (sorted_index !== exp_index) $display("[TB] FAIL stable_index: got %h, expected %h", sorted_index, exp_index);
    else passed++;
  endtask

  task automatic test_all_equal();
    int lat, want;
`ifdef SORT_EARLY_EXIT_EN
    want = 3;
`else
    want = LAT;
`endif
    for (int i = 0; i < NUM; i++) in_vals[i] = 18'sd5;
    build_expected(1'b1);
    launch(1'b1);
    wait_done(40, lat);
    checks++;
    if (lat !== want) $display("[TB] FAIL equal_latency: got %0d, expected %0d", lat, want);
    else passed++;
    checks++;
    if (sorted_data !== exp_data || sorted_index !== ident_index)
      $display("[TB] FAIL equal_result: got %h/%h, expected %h/%h", sorted_data, sorted_index, exp_data, ident_index);
    else passed++;
  endtask

  task automatic test_random();
    int lat;
    bit desc, lat_ok;
    for (int n = 0; n < 8; n++) begin
      desc = 1'($urandom);
      for (int i = 0; i < NUM; i++)
        in_vals[i] = (n < 4) ? DATA_W'($urandom) : DATA_W'(int'($urandom_range(0, 4)) - 2);
      build_expected(desc);
      launch(desc);
      wait_done(40, lat);
`ifdef SORT_EARLY_EXIT_EN
      lat_ok = (lat >= 3 && lat <= LAT);
`else
      lat_ok = (lat == LAT);
`endif
      checks++;
      if (!lat_ok) $display("[TB] FAIL random_latency[%0d]: got %0d, expected %0d", n, lat, LAT);
      else passed++;
      checks++;
      if (sorted_data !== exp_data) $display("[TB] FAIL random_data[%0d]: got %h, expected %h", n, sorted_data, exp_data);
      else passed++;
      checks++;
      if (sorted_index !== exp_index) $display("[TB] FAIL random_index[%0d]: got %h, expected %h", n, sorted_index, exp_index);
      else passed++;
      tick();
    end
  endtask

  task automatic test_ignore_and_hold();
    int lat;
    for (int i = 0; i < NUM; i++) in_vals[i] = DATA_W'($urandom);
    build_expected(1'b0);
    launch(1'b0);
    tick(); tick(); tick();
    start   = 1'b1;
    descend = 1'b1;
    in_data = ~in_data;
    tick();
    start   = 1'b0;
    wait_done(40, lat);
`ifndef SORT_EARLY_EXIT_EN
    checks++;
    if (lat + 4 !== LAT) $display("[TB] FAIL ignore_latency: got %0d, expected %0d", lat + 4, LAT);
    else passed++;
`endif
    checks++;
    if (sorted_data !== exp_data || sorted_index !== exp_index)
      $display("[TB] FAIL ignore_result: got %h/%h, expected %h/%h", sorted_data, sorted_index, exp_data, exp_index);
    else passed++;
    in_data = '0;
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (sorted_data !== exp_data || sorted_index !== exp_index || done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL hold_outputs: got %h/%h done=%b busy=%b, expected %h/%h 0 0",
               sorted_data, sorted_index, done, busy, exp_data, exp_index);
    else passed++;
  endtask

  task automatic test_abort();
    int lat;
    bit saw_done;
    for (int i = 0; i < NUM; i++) in_vals[i] = DATA_W'($urandom);
    launch(1'b1);
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL abort_ctrl: busy=%b done=%b, expected 0 0", busy, done);
    else passed++;
    checks++;
    if (sorted_data !== '0 || sorted_index !== ident_index)
      $display("[TB] FAIL abort_outputs: got %h/%h, expected 0/%h", sorted_data, sorted_index, ident_index);
    else passed++;
    saw_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) $display("[TB] FAIL abort_no_done: got %b, expected 0", saw_done);
    else passed++;
    build_expected(1'b0);
    launch(1'b0);
    wait_done(40, lat);
    checks++;
    if (lat < 1 || sorted_data !== exp_data || sorted_index !== exp_index)
      $display("[TB] FAIL abort_recover: lat=%0d got %h/%h, expected %h/%h", lat, sorted_data, sorted_index, exp_data, exp_index);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < NUM; i++) in_vals[i] = DATA_W'($urandom);
    pack_inputs();
    descend = 1'b0;
    start   = 1'b1;
    tick();
    descend = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_done(40, lat);
      if (s == 2) start = 1'b0;
      build_expected(s[0]);
`ifndef SORT_EARLY_EXIT_EN
      checks++;
      if ((s == 0 ? lat : lat + 1) !== (s == 0 ? LAT : LAT + 1))
        $display("[TB] FAIL b2b_spacing[%0d]: got %0d, expected %0d", s, (s == 0 ? lat : lat + 1), (s == 0 ? LAT : LAT + 1));
      else passed++;
`endif
      checks++;
      if (sorted_data !== exp_data || sorted_index !== exp_index)
        $display("[TB] FAIL b2b_result[%0d]: got %h/%h, expected %h/%h", s, sorted_data, sorted_index, exp_data, exp_index);
      else passed++;
      if (s < 2) begin
        tick();
        descend = ~descend;
      end
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    for (int k = 0; k < NUM; k++) ident_index[k*IDX_W +: IDX_W] = IDX_W'(k);
    test_reset();
    test_reverse();
    test_stability();
    test_all_equal();
    test_random();
    test_ignore_and_hold();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
